mem_arbiter: RTL

//  Shares the single-port system RAM between the CPU control path (fetch/load/store) and a debug/loader port.

---
 rtl/mem_arbiter_if.sv | 47 ++++
 rtl/mem_arbiter.sv | 99 +++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: CPU and debug req/ack ports, RAM strobes and status.
// The slave modport is the arbiter's side. The master modport is the requester/RAM side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic              ram_re;
    logic [DATA_W-1:0] ram_rdata;

    logic              busy;
    logic              owner;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  ram_rdata,
        output cpu_ack, cpu_rdata, dbg_ack, dbg_rdata,
        output ram_addr, ram_wdata, ram_we, ram_re,
        output busy, owner
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output ram_rdata,
        input  cpu_ack, cpu_rdata, dbg_ack, dbg_rdata,
        input  ram_addr, ram_wdata, ram_we, ram_re,
        input  busy, owner
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: CPU has fixed priority, and debug wins after MAX_WAIT
// consecutive CPU grants that it had to watch. Every output is registered.
module mem_arbiter #(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 32,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 8
) (
    input logic          clk,
    input logic          in_reset,
    mem_arbiter_if.slave bus
);
    localparam int SW = $clog2(MAX_WAIT + 1);
    localparam int WW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t        state;
    logic [SW-1:0] starv_cnt;
    logic [WW-1:0] wait_cnt;
    logic          txn_we;
    logic          pick_dbg;

    // Debug wins when it is the only requester, or when the CPU has used up its allowance.
    assign pick_dbg = bus.dbg_req && (!bus.cpu_req || starv_cnt == SW'(MAX_WAIT));

    always_ff @(posedge clk or posedge in_reset) begin
        if (in_reset) begin
            state         <= IDLE;
            starv_cnt     <= '0;
            wait_cnt      <= '0;
            txn_we        <= 1'b0;
            bus.cpu_ack   <= 1'b0;
            bus.dbg_ack   <= 1'b0;
            bus.cpu_rdata <= '0;
            bus.dbg_rdata <= '0;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
            bus.ram_we    <= 1'b0;
            bus.ram_re    <= 1'b0;
            bus.busy      <= 1'b0;
            bus.owner     <= 1'b0;
        end else begin
            bus.ram_we  <= 1'b0;
            bus.ram_re  <= 1'b0;
            bus.cpu_ack <= 1'b0;
            bus.dbg_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.dbg_req)
                        starv_cnt <= '0;
                    if (bus.cpu_req || bus.dbg_req) begin
                        bus.owner     <= pick_dbg;
                        txn_we        <= pick_dbg ? bus.dbg_we : bus.cpu_we;
                        bus.ram_we    <= pick_dbg ? bus.dbg_we : bus.cpu_we;
                        bus.ram_re    <= pick_dbg ? !bus.dbg_we : !bus.cpu_we;
                        bus.ram_addr  <= pick_dbg ? bus.dbg_addr : bus.cpu_addr;
                        bus.ram_wdata <= pick_dbg ? bus.dbg_wdata : bus.cpu_wdata;
                        if (pick_dbg)
                            starv_cnt <= '0;
                        else if (bus.dbg_req && starv_cnt != SW'(MAX_WAIT))
                            starv_cnt <= starv_cnt + 1'b1;
                        bus.busy <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (txn_we) begin
                        bus.cpu_ack <= !bus.owner;
                        bus.dbg_ack <= bus.owner;
                        state       <= ACK;
                    end else begin
                        wait_cnt <= WW'(RD_LAT - 1);
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    // The last WAIT cycle is the one where the RAM presents the read word.
                    if (wait_cnt == '0) begin
                        if (bus.owner)
                            bus.dbg_rdata <= bus.ram_rdata;
                        else
                            bus.cpu_rdata <= bus.ram_rdata;
                        bus.cpu_ack <= !bus.owner;
                        bus.dbg_ack <= bus.owner;
                        state       <= ACK;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ACK: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
